// File: rtl/banyan_capture_seq.sv
// ----------------------------------------------------------------------------
// banyan_capture_seq
//   Capture sequencer for the banyan-routed ADC snapshot memory (adc_clk
//   domain). It arms, waits for a selectable trigger, and runs the memory
//   until rollover. It can optionally rearm after a holdoff. It also counts
//   captures and the triggers that arrive while a capture is already busy.
//
// Ports
//   i_clk            adc_clk, all logic on the rising edge
//   i_rst            synchronous reset, active-high
//   i_arm            single-cycle arm request (IDLE/DONE only)
//   i_disarm         single-cycle; forces IDLE, wins over everything
//   i_auto_rearm     level; after rollover go to HOLDOFF instead of DONE
//   i_trig_sel       0 sw_trig, 1 ext rising edge, 2 either, 3 immediate
//   i_sw_trig        single-cycle software trigger
//   i_ext_trig       external trigger level, edge-detected here
//   i_holdoff        HOLDOFF length in cycles, sampled on HOLDOFF entry
//   i_data_valid     decimator output strobe
//   i_rollover       banyan_mem buffer-full indication
//   o_mem_reset      one-cycle reset pulse to banyan_mem (first RUN cycle)
//   o_mem_run        run strobe to banyan_mem
//   o_state          0 IDLE, 1 ARMED, 2 RUN, 3 HOLDOFF, 4 DONE
//   o_done           high in DONE
//   o_busy           high in ARMED, RUN or HOLDOFF
//   o_capture_count  number of RUN entries, wraps
//   o_missed_count   triggers seen in RUN/HOLDOFF, saturates
// ----------------------------------------------------------------------------
module banyan_capture_seq #(
  parameter int HW = 16,
  parameter int CW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_arm,
  input  logic          i_disarm,
  input  logic          i_auto_rearm,
  input  logic [1:0]    i_trig_sel,
  input  logic          i_sw_trig,
  input  logic          i_ext_trig,
  input  logic [HW-1:0] i_holdoff,
  input  logic          i_data_valid,
  input  logic          i_rollover,
  output logic          o_mem_reset,
  output logic          o_mem_run,
  output logic [2:0]    o_state,
  output logic          o_done,
  output logic          o_busy,
  output logic [CW-1:0] o_capture_count,
  output logic [CW-1:0] o_missed_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_RUN     = 3'd2,
    S_HOLDOFF = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t        r_state;
  logic          r_ext_d;
  logic          r_mem_reset;
  logic [HW-1:0] r_hold_cnt;
  logic [CW-1:0] r_cap_cnt;
  logic [CW-1:0] r_miss_cnt;

  logic          w_ext_rise;
  logic          w_src_evt;
  logic          w_trg;
  logic          w_busy_run;
  logic          w_miss_full;

  assign w_ext_rise = i_ext_trig & ~r_ext_d;

  // Source event from the selected trigger input(s). The immediate mode has
  // no external source, so it never produces a missed trigger.
  always_comb begin
    w_src_evt = 1'b0;
    case (i_trig_sel)
      2'd0:    w_src_evt = i_sw_trig;
      2'd1:    w_src_evt = w_ext_rise;
      2'd2:    w_src_evt = i_sw_trig | w_ext_rise;
      default: w_src_evt = 1'b0;
    endcase
  end

  assign w_trg       = w_src_evt | ((i_trig_sel == 2'd3) & (r_state == S_ARMED));
  assign w_busy_run  = (r_state == S_RUN) | (r_state == S_HOLDOFF);
  assign w_miss_full = &r_miss_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_ext_d     <= 1'b0;
      r_mem_reset <= 1'b0;
      r_hold_cnt  <= '0;
      r_cap_cnt   <= '0;
      r_miss_cnt  <= '0;
    end else begin
      r_ext_d     <= i_ext_trig;
      r_mem_reset <= 1'b0;

      if (w_busy_run && w_src_evt && !w_miss_full)
        r_miss_cnt <= r_miss_cnt + CW'(1);

      if (i_disarm) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_arm) r_state <= S_ARMED;
          end
          S_ARMED: begin
            if (w_trg) begin
              r_state     <= S_RUN;
              r_mem_reset <= 1'b1;
              r_cap_cnt   <= r_cap_cnt + CW'(1);
            end
          end
          S_RUN: begin
            // A rollover seen while the memory is still being reset belongs
            // to the previous fill and is dropped.
            if (i_rollover && !r_mem_reset) begin
              if (i_auto_rearm) begin
                r_state    <= S_HOLDOFF;
                r_hold_cnt <= i_holdoff;
              end else begin
                r_state    <= S_DONE;
              end
            end
          end
          S_HOLDOFF: begin
            // Leave when the decrement would reach zero. A zero holdoff still
            // spends one cycle here.
            if (r_hold_cnt <= HW'(1)) r_state    <= S_ARMED;
            else                      r_hold_cnt <= r_hold_cnt - HW'(1);
          end
          S_DONE: begin
            if (i_arm) r_state <= S_ARMED;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Run strobe handshake: banyan_mem consumes one sample on every cycle that
  // o_mem_run is high. There is no back-pressure, so o_mem_run simply
  // qualifies i_data_valid. It is suppressed during the reset pulse so that
  // no sample is written into a buffer that is being cleared.
  assign o_mem_run       = (r_state == S_RUN) & ~r_mem_reset & i_data_valid;
  assign o_mem_reset     = r_mem_reset;
  assign o_state         = r_state;
  assign o_done          = (r_state == S_DONE);
  assign o_busy          = (r_state == S_ARMED) | w_busy_run;
  assign o_capture_count = r_cap_cnt;
  assign o_missed_count  = r_miss_cnt;

endmodule

// File: doc/banyan_capture_seq.md
Name: banyan_capture_seq

Overview:
- Capture sequencer for the banyan-routed ADC snapshot memory in the adc_clk domain.
- Replaces the bare one-shot "trigger resets, rollover stops" logic with a sequencer providing:
  - arm/disarm control and a selectable trigger source;
  - an optional auto-rearm holdoff;
  - run gating by the decimator data_valid strobe;
  - capture and missed-trigger accounting for host status readout.
- Drives the reset and run inputs of banyan_mem and consumes its rollover output.

Parameters:
- hw, 16, width of holdoff counter (adc_clk cycles).
- cw, 16, width of capture_count and missed_count.

Ports:
- clk  input  1  adc_clk; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- arm  input  1  single-cycle; arms the sequencer.
- disarm  input  1  single-cycle; forces IDLE; has priority over arm.
- auto_rearm  input  1  level; after a completed capture, rearm following holdoff instead of stopping.
- trig_sel  input  2  trigger source: 0 sw_trig, 1 ext rising edge, 2 either, 3 immediate.
- sw_trig  input  1  single-cycle software trigger (already in adc_clk domain).
- ext_trig  input  1  level; edge-detected internally.
- holdoff  input  hw  cycles spent in HOLDOFF before rearm; sampled on entry to HOLDOFF.
- data_valid  input  1  decimator output strobe.
- rollover  input  1  from banyan_mem; buffer filled.
- mem_reset  output  1  to banyan_mem reset; one-cycle pulse.
- mem_run  output  1  to banyan_mem run.
- state  output  3  0 IDLE, 1 ARMED, 2 RUN, 3 HOLDOFF, 4 DONE.
- done  output  1  high in DONE.
- busy  output  1  high in ARMED, RUN or HOLDOFF.
- capture_count  output  cw  number of RUN entries; wraps modulo 2^cw.
- missed_count  output  cw  triggers seen in RUN or HOLDOFF; saturates at all-ones.

Behaviour:
- Reset values:
  - state=IDLE; all outputs 0; both counters 0; ext edge register 0.
  - rst asserted mid-RUN gives IDLE on the next edge; mem_run is low that cycle.
- Trigger event: trg = (sel0 & sw_trig) | (sel1 & ext_rise) | (sel3 & state==ARMED).
  - ext_rise = ext_trig & ~ext_d, where ext_d is registered each cycle in every state.
  - sel2 = sw_trig | ext_rise.
- IDLE:
  - arm -> ARMED next cycle.
  - Triggers are ignored and not counted.
- ARMED:
  - trg -> RUN next cycle.
  - mem_reset=1 for exactly that first RUN cycle (registered).
  - capture_count increments on the same edge.
  - trig_sel=3: ARMED lasts exactly one cycle.
- RUN:
  - mem_run = (state==RUN) & ~mem_reset & data_valid, combinational from registered terms. No run strobe coincides with the reset pulse.
  - rollover while auto_rearm=1 -> HOLDOFF.
  - rollover while auto_rearm=0 -> DONE.
  - rollover during the mem_reset cycle is ignored.
- HOLDOFF:
  - Counter loads holdoff on entry and decrements each cycle.
  - Count reaching 0 -> ARMED.
  - holdoff=0 gives HOLDOFF for exactly one cycle.
- DONE: done=1 and held. arm -> ARMED and clears done.
- disarm in any state -> IDLE next cycle, regardless of rollover or trg on the same cycle.
- arm while ARMED, RUN or HOLDOFF: ignored, no restart.
- missed_count increments on any trg-source event (sw_trig or ext_rise per trig_sel) while in RUN or HOLDOFF.
- Counters are cleared only by rst.
- busy and done are decoded combinationally from registered state.

Test Plan:
- Single shot: trig_sel=0; arm at cycle 10; sw_trig at 20 -> state RUN at 21, mem_reset high only at 21, capture_count=1. With data_valid=1, mem_run high from 22. rollover at 100 -> DONE at 101, done=1, mem_run=0.
- Ext edge: trig_sel=1; ext_trig held high before arm -> no trigger. Drop ext_trig then raise it at cycle 50 -> RUN at 51.
- Auto rearm: auto_rearm=1, holdoff=5, trig_sel=3 -> after rollover at N: HOLDOFF N+1..N+5, ARMED N+6, RUN N+7. capture_count increments each cycle of the loop. Repeat with holdoff=0 -> HOLDOFF N+1, ARMED N+2, RUN N+3.
- Gating: data_valid toggling 1-in-4 during RUN -> mem_run pulses only on data_valid cycles, never on the mem_reset cycle.
- Missed/priority:
  - 3 sw_trig pulses during RUN -> missed_count=3.
  - disarm and rollover on the same cycle -> IDLE, not DONE/HOLDOFF.
  - missed_count preset near all-ones via stimulus saturates at all-ones (cw=4 build: 15).
- Reset mid-run: rst during RUN -> next cycle state=0, counters 0, mem_run=0, done=0.
